button_bank: RTL and testbench

Parametrised N-channel pushbutton conditioner for the Tamagotchi front end; replaces the per-button debouncer/press-counter instances at the top level with one bank. Each channel provides input synchronisation, debounce, press/release/short/long event pulses and a wrapping press counter. Outputs feed the central FSM: sleep, play and test buttons, with the counter replacing the test pulse count.

---
 rtl/button_bank.sv | 175 +++++++++++++++++
 tb/tb_button_bank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// N-channel pushbutton conditioner: synchroniser, debounce, press/release/short/long events and press counter.
// Optional auto-repeat while held long is built when BUTTON_BANK_REPEAT_EN is defined.
module button_bank #(
  parameter int N_CH     = 4,
  parameter int DEB_CYC  = 1000000,
  parameter int LONG_CYC = 50000000,
  parameter int REP_CYC  = 10000000,
  parameter int CNT_W    = 4,
  parameter int ACT_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         btn_in,
  input  logic [N_CH-1:0]         clr_cnt,
  output logic [N_CH-1:0]         level,
  output logic [N_CH-1:0]         press,
  output logic [N_CH-1:0]         release_p,
  output logic [N_CH-1:0]         short_p,
  output logic [N_CH-1:0]         long_p,
  output logic [N_CH*CNT_W-1:0]   count
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
`ifdef BUTTON_BANK_REPEAT_EN
  localparam int REP_W  = $clog2(REP_CYC + 1);
`endif

  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic              pin_act;
      logic [1:0]        sync_reg;
      logic [DEB_W-1:0]  deb_reg, deb_next;
      logic              level_reg, level_next;
      logic              acc_press, acc_rel;
      state_t            state_reg, state_next;
      logic [HOLD_W-1:0] hold_reg, hold_next;
      logic              press_reg, press_next;
      logic              rel_reg, rel_next;
      logic              short_reg, short_next;
      logic              long_reg, long_next;
      logic [CNT_W-1:0]  cnt_reg, cnt_next;
      logic              cnt_inc;
`ifdef BUTTON_BANK_REPEAT_EN
      logic [REP_W-1:0]  rep_reg, rep_next;
`endif

      assign pin_act = (ACT_LOW != 0) ? ~btn_in[gi] : btn_in[gi];

      // A change is accepted on the cycle the mismatch run reaches DEB_CYC.
      always_comb begin
        deb_next   = '0;
        level_next = level_reg;
        acc_press  = 1'b0;
        acc_rel    = 1'b0;
        if (sync_reg[1] != level_reg) begin
          if (deb_reg == DEB_W'(DEB_CYC - 1)) begin
            level_next = sync_reg[1];
            acc_press  = sync_reg[1];
            acc_rel    = ~sync_reg[1];
          end else begin
            deb_next = deb_reg + DEB_W'(1);
          end
        end
      end

      always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        press_next = 1'b0;
        rel_next   = 1'b0;
        short_next = 1'b0;
        long_next  = 1'b0;
        cnt_inc    = 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
        rep_next   = rep_reg;
`endif
        case (state_reg)
          IDLE: begin
            if (acc_press) begin
              state_next = PRESSED;
              press_next = 1'b1;
              hold_next  = '0;
              cnt_inc    = 1'b1;
            end
          end
          PRESSED: begin
            if (acc_rel) begin
              state_next = IDLE;
              rel_next   = 1'b1;
              short_next = 1'b1;
            end else if (hold_reg == HOLD_W'(LONG_CYC - 1)) begin
              state_next = LONG_HELD;
              long_next  = 1'b1;
              hold_next  = HOLD_W'(LONG_CYC);
`ifdef BUTTON_BANK_REPEAT_EN
              rep_next   = '0;
`endif
            end else begin
              hold_next = hold_reg + HOLD_W'(1);
            end
          end
          LONG_HELD: begin
            if (acc_rel) begin
              state_next = IDLE;
              rel_next   = 1'b1;
            end
`ifdef BUTTON_BANK_REPEAT_EN
            else if (rep_reg == REP_W'(REP_CYC - 1)) begin
              rep_next   = '0;
              press_next = 1'b1;
              cnt_inc    = 1'b1;
            end else begin
              rep_next = rep_reg + REP_W'(1);
            end
`endif
          end
          default: state_next = IDLE;
        endcase
      end

      // Clear has priority over a coincident increment.
      always_comb begin
        cnt_next = cnt_reg;
        if (clr_cnt[gi])
          cnt_next = '0;
        else if (cnt_inc)
          cnt_next = cnt_reg + CNT_W'(1);
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_reg  <= '0;
          deb_reg   <= '0;
          level_reg <= 1'b0;
          state_reg <= IDLE;
          hold_reg  <= '0;
          press_reg <= 1'b0;
          rel_reg   <= 1'b0;
          short_reg <= 1'b0;
          long_reg  <= 1'b0;
          cnt_reg   <= '0;
`ifdef BUTTON_BANK_REPEAT_EN
          rep_reg   <= '0;
`endif
        end else begin
          sync_reg  <= {sync_reg[0], pin_act};
          deb_reg   <= deb_next;
          level_reg <= level_next;
          state_reg <= state_next;
          hold_reg  <= hold_next;
          press_reg <= press_next;
          rel_reg   <= rel_next;
          short_reg <= short_next;
          long_reg  <= long_next;
          cnt_reg   <= cnt_next;
`ifdef BUTTON_BANK_REPEAT_EN
          rep_reg   <= rep_next;
`endif
        end
      end

      assign level[gi]                  = level_reg;
      assign press[gi]                  = press_reg;
      assign release_p[gi]              = rel_reg;
      assign short_p[gi]                = short_reg;
      assign long_p[gi]                 = long_reg;
      assign count[gi*CNT_W +: CNT_W]   = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_button_bank.sv
// Randomised and directed bench for button_bank; a timestamp/window reference model feeds a scoreboard queue.
module tb_button_bank;
  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;
  localparam int CW   = 4;
`ifdef BUTTON_BANK_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif
  localparam int VW = 5 * N + N * CW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    btn_in = '1;
  logic [N-1:0]    clr_cnt = '0;
  logic [N-1:0]    level, press, release_p, short_p, long_p;
  logic [N*CW-1:0] count;

  button_bank #(.N_CH(N), .DEB_CYC(DEB), .LONG_CYC(LONG), .REP_CYC(REP),
                .CNT_W(CW), .ACT_LOW(1)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .clr_cnt(clr_cnt),
    .level(level), .press(press), .release_p(release_p), .short_p(short_p),
    .long_p(long_p), .count(count));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [VW-1:0] exp_q[$];
  bit mon_en = 0;

  logic         r_v = 1'b0;
  logic [N-1:0] btn_v = '1;
  logic [N-1:0] clr_v = '0;

  // Reference model: level from a window of raw samples, events from edge timestamps.
  bit hist[N][DEB+2];
  bit m_lvl[N], m_long[N], m_p[N], m_r[N], m_s[N], m_l[N];
  int m_pedge[N], m_ledge[N], m_cnt[N];
  int cyc = 0;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < DEB + 2; i++) hist[c][i] = 1'b0;
      m_lvl[c] = 0; m_long[c] = 0; m_p[c] = 0; m_r[c] = 0; m_s[c] = 0; m_l[c] = 0;
      m_cnt[c] = 0; m_pedge[c] = 0; m_ledge[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit acc, inc;
    if (!rst) return;
    cyc++;
    for (int c = 0; c < N; c++) begin
      for (int i = DEB + 1; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = !btn_in[c];
      acc = 1;
      for (int i = 2; i <= DEB + 1; i++) if (hist[c][i] == m_lvl[c]) acc = 0;
      m_p[c] = 0; m_r[c] = 0; m_s[c] = 0; m_l[c] = 0; inc = 0;
      if (acc && !m_lvl[c]) begin
        m_p[c] = 1; m_pedge[c] = cyc; m_long[c] = 0; inc = 1; m_lvl[c] = 1;
      end else if (acc && m_lvl[c]) begin
        m_r[c] = 1; m_s[c] = !m_long[c]; m_lvl[c] = 0;
      end else if (m_lvl[c] && !m_long[c] && (cyc - m_pedge[c] == LONG)) begin
        m_l[c] = 1; m_long[c] = 1; m_ledge[c] = cyc;
      end else if (REP_ON && m_lvl[c] && m_long[c] && cyc > m_ledge[c] &&
                   ((cyc - m_ledge[c]) % REP == 0)) begin
        m_p[c] = 1; inc = 1;
      end
      if (clr_cnt[c]) m_cnt[c] = 0;
      else if (inc) m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
    end
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [N-1:0] l, p, r, s, lg;
    logic [N*CW-1:0] cn;
    for (int c = 0; c < N; c++) begin
      l[c] = m_lvl[c]; p[c] = m_p[c]; r[c] = m_r[c]; s[c] = m_s[c]; lg[c] = m_l[c];
      cn[c*CW +: CW] = CW'(m_cnt[c]);
    end
    return {l, p, r, s, lg, cn};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    rst = r_v; btn_in = btn_v; clr_cnt = clr_v;
    if (!r_v) model_reset();
    exp_q.push_back(model_vec());
    mon_en = 1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end else
      $display("check %s ok: %0d", name, act);
  endtask

  // Scoreboard monitor: one expected vector per cycle, compared mid-cycle.
  initial begin
    logic [VW-1:0] e, a;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        a = {level, press, release_p, short_p, long_p, count};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_empty: got %h expected <entry> (t=%0t)", a, $time);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL scoreboard: got %h expected %h (t=%0t)", a, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rem[N];
    int lp_cnt, lp_at;
    model_reset();
    // Reset held with random pin activity.
    r_v = 0;
    for (int i = 0; i < 12; i++) begin btn_v = N'($urandom); tick(); end
    #1; chk("reset_outputs", int'({level, press, release_p, short_p, long_p, count}), 0);
    r_v = 1; btn_v = '1; tick(); tick();
    #1; chk("post_reset_level", int'(level), 0);
    chk("post_reset_count", int'(count), 0);

    // Clean press/release on ch0.
    btn_v[0] = 0; repeat (6) tick();
    #1; chk("press0_early", int'(press[0]), 0);
    tick(); #1;
    chk("press0", int'(press[0]), 1);
    chk("level0", int'(level[0]), 1);
    chk("count0_one", int'(count[CW-1:0]), 1);
    tick(); #1; chk("press0_width", int'(press[0]), 0);
    repeat (8) tick();
    btn_v[0] = 1; repeat (7) tick(); #1;
    chk("release0", int'(release_p[0]), 1);
    chk("short0", int'(short_p[0]), 1);
    chk("level0_low", int'(level[0]), 0);

    // Glitch on ch1.
    btn_v[1] = 0; repeat (3) tick();
    btn_v[1] = 1; repeat (10) tick(); #1;
    chk("glitch_level1", int'(level[1]), 0);
    chk("glitch_count1", int'(count[2*CW-1:CW]), 0);

    // Long press on ch1.
    btn_v[1] = 0; repeat (7) tick(); #1;
    chk("press1", int'(press[1]), 1);
    lp_cnt = 0; lp_at = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(); #1;
      if (long_p[1]) begin lp_cnt++; lp_at = i; end
    end
    chk("long1_once", lp_cnt, 1);
    chk("long1_delay", lp_at, LONG);
    btn_v[1] = 1; repeat (7) tick(); #1;
    chk("release1", int'(release_p[1]), 1);
    chk("short1_absent", int'(short_p[1]), 0);

    // Wrap: clear then 16 presses.
    clr_v[0] = 1; tick(); clr_v[0] = 0;
    for (int k = 0; k < 16; k++) begin
      btn_v[0] = 0; repeat (8) tick();
      btn_v[0] = 1; repeat (8) tick();
    end
    #1; chk("wrap_count0", int'(count[CW-1:0]), 0);
    btn_v[0] = 0; repeat (8) tick();
    btn_v[0] = 1; repeat (8) tick();
    #1; chk("count0_after_wrap", int'(count[CW-1:0]), 1);
    // Clear sampled on the same edge as the accepted press.
    btn_v[0] = 0; repeat (5) tick();
    clr_v[0] = 1; tick(); clr_v[0] = 0; tick(); #1;
    chk("clr_press_coincide", int'(press[0]), 1);
    chk("clr_wins", int'(count[CW-1:0]), 0);

    // Reset mid-hold, button kept pressed.
    repeat (4) tick();
    r_v = 0; tick(); #1;
    chk("midhold_reset", int'({level, press, release_p, short_p, long_p, count}), 0);
    r_v = 1; repeat (7) tick(); #1;
    chk("repress0", int'(press[0]), 1);
    chk("repress0_count", int'(count[CW-1:0]), 1);
    btn_v[0] = 1; repeat (8) tick();

    // Random phase.
    for (int c = 0; c < N; c++) rem[c] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          btn_v[c] = ~btn_v[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEB + 1)
                                               : $urandom_range(DEB + 2, 45);
        end
      end
      clr_v = '0;
      for (int c = 0; c < N; c++) if ($urandom_range(0, 39) == 0) clr_v[c] = 1;
      r_v = !(i >= 1500 && i < 1503);
      tick();
    end
    r_v = 1; clr_v = '0;
    repeat (2) tick();
    @(negedge clk); #1;
    mon_en = 0;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
